// File: rtl/dac_seq_pkg.sv
// Shared types and default widths for the DAC sample playback sequencer.
package dac_seq_pkg;

  localparam int DAC_ADDR_W = 9;
  localparam int DAC_DATA_W = 8;
  localparam int DAC_DIV_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rate_counter.sv
// Loadable down-counter that paces samples. zero_o marks the terminal count.
module rate_counter
  import dac_seq_pkg::*;
#(
  parameter int W = DAC_DIV_W
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Saturates at zero so a stray decrement can never wrap into a long hold.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dac_sample_sequencer.sv
// Reads samples 0..length from the shared RAM and plays them onto the DAC pins.
//   state | meaning
//   IDLE  | stopped, address parked at 0
//   FETCH | read request outstanding, waiting for grant
//   LATCH | read data arriving this cycle, captured onto dac
//   HOLD  | sample on dac, counting down divider
module dac_sample_sequencer
  import dac_seq_pkg::*;
#(
  parameter int ADDR_W = DAC_ADDR_W,
  parameter int DATA_W = DAC_DATA_W,
  parameter int DIV_W  = DAC_DIV_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              run,
  input  logic              loop,
  input  logic [ADDR_W-1:0] length,
  input  logic [DIV_W-1:0]  divider,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] dac,
  output logic              dac_start,
  output logic              addr_zero,
  output logic              state_run,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              dac_start_q, dac_start_d;
  logic              done_q, done_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  rate_counter #(.W(DIV_W)) u_rate (
    .clk        (clk),
    .rstb       (rstb),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (divider),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dac_d       = dac_q;
    dac_start_d = 1'b0;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    // Dropping run aborts from any active state; a grant arriving now is ignored.
    if ((state_q != ST_IDLE) && !run) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_d = '0;
          if (run) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (ram_gnt) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          dac_d       = ram_rdata;
          dac_start_d = 1'b1;
          cnt_load    = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (addr_q != length) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end else if (loop) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      dac_q       <= '0;
      dac_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dac_q       <= dac_d;
      dac_start_q <= dac_start_d;
      done_q      <= done_d;
    end
  end

  assign ram_req   = (state_q == ST_FETCH);
  assign ram_addr  = addr_q;
  assign dac       = dac_q;
  assign dac_start = dac_start_q;
  assign done      = done_q;
  assign addr_zero = (addr_q == '0);
  assign state_run = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Bench for dac_sample_sequencer: timeline model compared every cycle plus directed scenarios.
module tb_dac_sample_sequencer;

  logic        clk = 1'b0;
  logic        rstb, run, loop, ram_req, ram_gnt, dac_start, addr_zero, state_run, done;
  logic [8:0]  length, ram_addr;
  logic [15:0] divider;
  logic [7:0]  ram_rdata = 8'hEE;
  logic [7:0]  dac;

  logic [7:0] mem [512];
  int  n_err = 0, n_checks = 0;
  int  stall_left = 0;
  bit  cmp_en = 0;
  bit  seen;

  // timeline model state
  int         cyc = 0;
  bit         m_active = 0, m_fetch = 0, m_latch_due = 0, m_ds = 0, m_done = 0;
  logic [8:0] m_addr = '0;
  logic [7:0] m_dac = '0, m_pend = '0;
  int         m_end = -1;

  int         ds_t[$];
  logic [7:0] ds_v[$];
  int         done_t[$];

  always #5 clk = ~clk;

  dac_sample_sequencer dut (
    .clk       (clk),
    .rstb      (rstb),
    .run       (run),
    .loop      (loop),
    .length    (length),
    .divider   (divider),
    .ram_req   (ram_req),
    .ram_gnt   (ram_gnt),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .dac       (dac),
    .dac_start (dac_start),
    .addr_zero (addr_zero),
    .state_run (state_run),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM: data valid exactly one cycle after an accepted request
  always @(posedge clk) ram_rdata <= (ram_req && ram_gnt) ? mem[ram_addr] : 8'hEE;

  // Arbiter: optionally withholds the grant for addr 1
  initial begin
    ram_gnt = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && ram_req && ram_addr == 9'd1) begin
        ram_gnt = 1'b0;
        stall_left--;
      end else begin
        ram_gnt = 1'b1;
      end
    end
  end

  // Model: tracks the playback timeline in absolute cycles
  initial forever begin
    @(posedge clk);
    cyc++;
    m_ds = 0;
    m_done = 0;
    if (!rstb) begin
      m_active = 0; m_fetch = 0; m_latch_due = 0; m_addr = '0; m_dac = '0; m_end = -1;
    end else if (!m_active) begin
      if (run) begin m_active = 1; m_fetch = 1; end
    end else if (!run) begin
      m_active = 0; m_fetch = 0; m_latch_due = 0; m_addr = '0; m_end = -1;
    end else if (m_fetch) begin
      if (ram_gnt) begin m_fetch = 0; m_latch_due = 1; m_pend = mem[m_addr]; end
    end else if (m_latch_due) begin
      m_latch_due = 0;
      m_dac = m_pend;
      m_ds = 1;
      m_end = cyc + int'(divider) + 1;
    end else if (cyc == m_end) begin
      if (m_addr != length) begin
        m_addr = m_addr + 9'd1; m_fetch = 1;
      end else if (loop) begin
        m_addr = '0; m_fetch = 1;
      end else begin
        m_done = 1; m_active = 0; m_addr = '0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("ram_req",   32'(ram_req),   32'(m_active && m_fetch));
      chk("ram_addr",  32'(ram_addr),  32'(m_addr));
      chk("dac",       32'(dac),       32'(m_dac));
      chk("dac_start", 32'(dac_start), 32'(m_ds));
      chk("done",      32'(done),      32'(m_done));
      chk("addr_zero", 32'(addr_zero), 32'(m_addr == 9'd0));
      chk("state_run", 32'(state_run), 32'(m_active));
      if (m_ds) begin ds_t.push_back(cyc); ds_v.push_back(m_dac); end
      if (m_done) done_t.push_back(cyc);
    end
  end

  task automatic clear_log();
    ds_t.delete();
    ds_v.delete();
    done_t.delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (m_done) ok = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    rstb = 1'b0; run = 1'b0; loop = 1'b0; length = 9'd2; divider = 16'd4;
    repeat (2) @(negedge clk);
    chk("rst_state_run", 32'(state_run), 32'd0);
    chk("rst_dac",       32'(dac),       32'd0);
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    chk("rst_ram_req",   32'(ram_req),   32'd0);
    chk("rst_done",      32'(done),      32'd0);
    rstb = 1'b1;
    cmp_en = 1;

    // one-shot playback of 3 samples, divider 4
    clear_log();
    run = 1'b1;
    wait_done(100, seen);
    chk("a_done_seen", 32'(seen), 32'd1);
    run = 1'b0;
    repeat (10) @(negedge clk);
    chk("a_ds_count", 32'(ds_t.size()), 32'd3);
    chk("a_done_count", 32'(done_t.size()), 32'd1);
    if (ds_t.size() >= 3 && done_t.size() >= 1) begin
      chk("a_v0", 32'(ds_v[0]), 32'h10);
      chk("a_v1", 32'(ds_v[1]), 32'h20);
      chk("a_v2", 32'(ds_v[2]), 32'h30);
      chk("a_period0", 32'(ds_t[1] - ds_t[0]), 32'd7);
      chk("a_period1", 32'(ds_t[2] - ds_t[1]), 32'd7);
      chk("a_done_delay", 32'(done_t[0] - ds_t[2]), 32'd5);
    end

    // looped playback wraps to address 0, no done
    loop = 1'b1;
    clear_log();
    run = 1'b1;
    repeat (40) @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_done_count", 32'(done_t.size()), 32'd0);
    chk("b_ds_count", 32'(ds_t.size()), 32'd6);
    if (ds_t.size() >= 5) begin
      chk("b_v3", 32'(ds_v[3]), 32'h10);
      chk("b_v4", 32'(ds_v[4]), 32'h20);
      chk("b_wrap_period", 32'(ds_t[3] - ds_t[2]), 32'd7);
    end

    // grant withheld 5 cycles during fetch of addr 1
    loop = 1'b0;
    clear_log();
    stall_left = 5;
    run = 1'b1;
    wait_done(100, seen);
    chk("c_done_seen", 32'(seen), 32'd1);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("c_stall_used", 32'(stall_left), 32'd0);
    if (ds_t.size() >= 3) begin
      chk("c_period_stall", 32'(ds_t[1] - ds_t[0]), 32'd12);
      chk("c_v1", 32'(ds_v[1]), 32'h20);
      chk("c_period_after", 32'(ds_t[2] - ds_t[1]), 32'd7);
    end

    // abort during hold of 0x20, then restart from address 0
    clear_log();
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (m_ds && m_dac == 8'h20) seen = 1;
    end
    chk("d_reached_0x20", 32'(seen), 32'd1);
    run = 1'b0;
    @(negedge clk);
    chk("d_state_run", 32'(state_run), 32'd0);
    chk("d_dac_held",  32'(dac),       32'h20);
    chk("d_ram_addr",  32'(ram_addr),  32'd0);
    repeat (10) @(negedge clk);
    chk("d_no_done", 32'(done_t.size()), 32'd0);
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dac_start) seen = 1;
    end
    chk("d_restart_seen", 32'(seen), 32'd1);
    chk("d_restart_dac", 32'(dac), 32'h10);
    run = 1'b0;
    repeat (3) @(negedge clk);

    // divider 0, single looped sample
    divider = 16'd0; length = 9'd0; loop = 1'b1;
    clear_log();
    run = 1'b1;
    repeat (20) @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("e_ds_count", 32'(ds_t.size()), 32'd6);
    if (ds_t.size() >= 3) begin
      chk("e_period0", 32'(ds_t[1] - ds_t[0]), 32'd3);
      chk("e_period1", 32'(ds_t[2] - ds_t[1]), 32'd3);
      chk("e_v2", 32'(ds_v[2]), 32'h10);
    end

    // reset mid-hold
    divider = 16'd4; length = 9'd2; loop = 1'b0;
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_ds) seen = 1;
    end
    chk("f_in_hold", 32'(seen), 32'd1);
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    chk("f_state_run", 32'(state_run), 32'd0);
    chk("f_dac",       32'(dac),       32'd0);
    chk("f_ram_addr",  32'(ram_addr),  32'd0);
    chk("f_addr_zero", 32'(addr_zero), 32'd1);
    rstb = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

endmodule
